// File: rtl/ps2_kbd_rx_if.sv
// Raw scan-code FIFO read port of the PS/2 keyboard receiver.
// The receiver is the master; the consumer pops bytes through the slave side.
interface ps2_kbd_rx_if;
  logic       fifo_valid;
  logic [7:0] fifo_data;
  logic       fifo_rd;

  modport master (output fifo_valid, output fifo_data, input fifo_rd);
  modport slave  (input fifo_valid, input fifo_data, output fifo_rd);
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deserialises and validates frames, buffers raw bytes
// in a FIFO and tracks the currently held key plus a press counter.
module ps2_kbd_rx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_kbd_rx_if.master       bus,
  output logic               overflow,
  output logic               frame_err,
  output logic [7:0]         cur_code,
  output logic               key_down,
  output logic [7:0]         press_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic                         clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic                         dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [3:0]                   bit_cnt_q, bit_cnt_d;
  logic [9:0]                   frame_q, frame_d;
  logic [TW-1:0]                to_cnt_q, to_cnt_d;
  logic                         frame_err_q, frame_err_d;
  logic [FIFO_DEPTH-1:0][7:0]   mem_q, mem_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         fifo_valid_q, fifo_valid_d;
  logic                         overflow_q, overflow_d;
  logic [7:0]                   cur_code_q, cur_code_d;
  logic                         key_down_q, key_down_d;
  logic [7:0]                   press_cnt_q, press_cnt_d;
  logic                         brk_q, brk_d;

  logic       fall_c, stop_c, good_c, rd_en_c, wr_en_c, full_c;
  logic [7:0] byte_c;

  always_comb begin
    clk_s1_d     = ps2_clk;
    clk_s2_d     = clk_s1_q;
    clk_prev_d   = clk_s2_q;
    dat_s1_d     = ps2_data;
    dat_s2_d     = dat_s1_q;
    bit_cnt_d    = bit_cnt_q;
    frame_d      = frame_q;
    to_cnt_d     = to_cnt_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    cur_code_d   = cur_code_q;
    key_down_d   = key_down_q;
    press_cnt_d  = press_cnt_q;
    brk_d        = brk_q;

    // Frame bits shift in LSB first: frame_q[0]=start, [8:1]=data, [9]=parity.
    fall_c = clk_prev_q & ~clk_s2_q;
    stop_c = fall_c && (bit_cnt_q == 4'd10);
    byte_c = frame_q[8:1];
    good_c = stop_c && !frame_q[0] && (^frame_q[9:1]) && dat_s2_q;
    frame_err_d = stop_c && !good_c;

    if (fall_c) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        frame_d   = {dat_s2_q, frame_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    full_c  = (count_q == CW'(FIFO_DEPTH));
    rd_en_c = bus.fifo_rd && (count_q != '0);
    wr_en_c = good_c && (!full_c || rd_en_c);
    if (wr_en_c) begin
      mem_d[wr_ptr_q] = byte_c;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en_c) rd_ptr_d = rd_ptr_q + AW'(1);
    if (good_c && !wr_en_c) overflow_d = 1'b1;
    count_d      = count_q + CW'(wr_en_c) - CW'(rd_en_c);
    fifo_valid_d = (count_d != '0);

    // Make/break tracker; E0 prefixes are transparent so extended keys report their base code.
    if (good_c) begin
      if (byte_c == CODE_EXT) begin
        brk_d = brk_q;
      end else if (byte_c == CODE_BRK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        if (byte_c == cur_code_q) begin
          key_down_d = 1'b0;
          cur_code_d = 8'h00;
        end
      end else if (!key_down_q || (byte_c != cur_code_q)) begin
        cur_code_d  = byte_c;
        key_down_d  = 1'b1;
        press_cnt_d = press_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      bit_cnt_q    <= 4'd0;
      frame_q      <= '0;
      to_cnt_q     <= '0;
      frame_err_q  <= 1'b0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      cur_code_q   <= 8'h00;
      key_down_q   <= 1'b0;
      press_cnt_q  <= 8'h00;
      brk_q        <= 1'b0;
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      clk_prev_q   <= clk_prev_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_q      <= frame_d;
      to_cnt_q     <= to_cnt_d;
      frame_err_q  <= frame_err_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_valid_q <= fifo_valid_d;
      overflow_q   <= overflow_d;
      cur_code_q   <= cur_code_d;
      key_down_q   <= key_down_d;
      press_cnt_q  <= press_cnt_d;
      brk_q        <= brk_d;
    end
  end

  // When empty, keep showing the most recently popped entry.
  assign bus.fifo_data  = fifo_valid_q ? mem_q[rd_ptr_q] : mem_q[rd_ptr_q - AW'(1)];
  assign bus.fifo_valid = fifo_valid_q;
  assign overflow       = overflow_q;
  assign frame_err      = frame_err_q;
  assign cur_code       = cur_code_q;
  assign key_down       = key_down_q;
  assign press_cnt      = press_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: PS/2 frames driven bit by bit and compared
// against a byte-level FIFO/key-tracker reference model.
module tb_ps2_kbd_rx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 300;
  localparam int unsigned HP    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       overflow, frame_err, key_down;
  logic [7:0] cur_code, press_cnt;

  ps2_kbd_rx_if bus();

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus.master),
    .overflow(overflow), .frame_err(frame_err), .cur_code(cur_code),
    .key_down(key_down), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cycles = 0;

  always @(posedge clk) if (frame_err) err_cycles++;

  // Reference model: queue of stored bytes plus held-key state.
  logic [7:0] mq[$];
  logic       m_ovf, m_down, m_brk;
  logic [7:0] m_cur, m_cnt;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0; m_down = 0; m_brk = 0; m_cur = 8'h00; m_cnt = 8'h00;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1;
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (m_brk) begin
      m_brk = 0;
      if (b == m_cur) begin m_down = 0; m_cur = 8'h00; end
      return;
    end
    if (!(m_down && b == m_cur)) begin
      m_cur = b; m_down = 1; m_cnt = m_cnt + 8'd1;
    end
  endfunction

  // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop
  function automatic logic [10:0] mk(input logic [7:0] b, input int kind);
    return {(kind != 3), (~^b) ^ (kind == 1), b, (kind == 2)};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_data = bits[i];
      repeat (HP) @(negedge clk); ps2_clk = 1'b0;
      repeat (HP) @(negedge clk); ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int kind);
    send_bits(mk(b, kind), 11);
    repeat (4) @(negedge clk);
    if (kind == 0) model_byte(b);
  endtask

  task automatic pop_byte(output logic [7:0] d);
    d = bus.fifo_data;
    bus.fifo_rd = 1'b1;
    @(negedge clk);
    bus.fifo_rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; bus.fifo_rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.fifo_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_valid: got %b want 0", bus.fifo_valid); end
    n_tests++; if (bus.fifo_data !== 8'h00) begin n_fail++; $display("FAIL reset_fifo_data: got %h want 00", bus.fifo_data); end
    n_tests++; if ({overflow, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {overflow, frame_err}); end
    n_tests++; if ({key_down, cur_code, press_cnt} !== 17'h0) begin n_fail++; $display("FAIL reset_tracker: got %h want 0", {key_down, cur_code, press_cnt}); end
  endtask

  task automatic test_single_make();
    int lat;
    do_reset();
    send_bits(mk(8'h1C, 0), 10);
    @(negedge clk); ps2_data = 1'b1;
    repeat (HP) @(negedge clk); ps2_clk = 1'b0;
    lat = 0;
    while (lat < 10 && !bus.fifo_valid) begin @(negedge clk); lat++; end
    // 2 synchroniser stages + 1 clk update
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL make_latency: got %0d cycles want 3", lat); end
    repeat (HP) @(negedge clk); ps2_clk = 1'b1;
    model_byte(8'h1C);
    n_tests++; if (bus.fifo_data !== 8'h1C) begin n_fail++; $display("FAIL make_data: got %h want 1c", bus.fifo_data); end
    n_tests++; if (cur_code !== 8'h1C || key_down !== 1'b1) begin n_fail++; $display("FAIL make_key: got %h/%b want 1c/1", cur_code, key_down); end
    n_tests++; if (press_cnt !== 8'd1) begin n_fail++; $display("FAIL make_cnt: got %0d want 1", press_cnt); end
  endtask

  task automatic test_typematic_release();
    logic [7:0] seq [5];
    logic [7:0] d;
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(seq[i], 0);
    n_tests++; if (press_cnt !== 8'd1 || key_down !== 1'b1) begin n_fail++; $display("FAIL typematic_cnt: got %0d/%b want 1/1", press_cnt, key_down); end
    for (int i = 3; i < 5; i++) send_frame(seq[i], 0);
    n_tests++; if (press_cnt !== 8'd1) begin n_fail++; $display("FAIL release_cnt: got %0d want 1", press_cnt); end
    n_tests++; if (cur_code !== 8'h00 || key_down !== 1'b0) begin n_fail++; $display("FAIL release_key: got %h/%b want 00/0", cur_code, key_down); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (bus.fifo_valid !== 1'b1) begin n_fail++; $display("FAIL release_fifo_valid[%0d]: got %b want 1", i, bus.fifo_valid); end
      pop_byte(d);
      n_tests++; if (d !== seq[i]) begin n_fail++; $display("FAIL release_fifo_order[%0d]: got %h want %h", i, d, seq[i]); end
    end
    n_tests++; if (bus.fifo_valid !== 1'b0) begin n_fail++; $display("FAIL release_drained: got %b want 0", bus.fifo_valid); end
    // Popping with the FIFO empty is ignored and the last head byte stays visible.
    bus.fifo_rd = 1'b1; @(negedge clk); bus.fifo_rd = 1'b0; @(negedge clk);
    n_tests++; if (bus.fifo_data !== 8'h1C || bus.fifo_valid !== 1'b0) begin n_fail++; $display("FAIL empty_hold: got %h/%b want 1c/0", bus.fifo_data, bus.fifo_valid); end
  endtask

  task automatic test_bad_frames();
    int e0;
    do_reset();
    send_frame(8'h32, 0);
    for (int kind = 1; kind <= 3; kind++) begin
      e0 = err_cycles;
      send_frame(8'h1C, kind);
      n_tests++; if (err_cycles - e0 !== 1) begin n_fail++; $display("FAIL bad_err_pulse[%0d]: got %0d cycles want 1", kind, err_cycles - e0); end
      n_tests++; if (bus.fifo_data !== 8'h32 || bus.fifo_valid !== 1'b1) begin n_fail++; $display("FAIL bad_fifo[%0d]: got %h/%b want 32/1", kind, bus.fifo_data, bus.fifo_valid); end
      n_tests++; if (cur_code !== m_cur || press_cnt !== m_cnt) begin n_fail++; $display("FAIL bad_tracker[%0d]: got %h/%0d want %h/%0d", kind, cur_code, press_cnt, m_cur, m_cnt); end
    end
    bus.fifo_rd = 1'b1; @(negedge clk); bus.fifo_rd = 1'b0; @(negedge clk);
    n_tests++; if (bus.fifo_valid !== 1'b0) begin n_fail++; $display("FAIL bad_no_extra_bytes: got %b want 0", bus.fifo_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] b, prev, d;
    do_reset();
    prev = 8'h00;
    for (int i = 0; i < 9; i++) begin
      do b = 8'($urandom_range(1, 8'hDF)); while (b == prev);
      prev = b;
      send_frame(b, 0);
      if (i == 7) begin
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_tests++; if (cur_code !== prev || press_cnt !== 8'd9) begin n_fail++; $display("FAIL ovf_tracker: got %h/%0d want %h/9", cur_code, press_cnt, prev); end
    for (int i = 0; i < DEPTH; i++) begin
      pop_byte(d);
      n_tests++; if (d !== mq[0]) begin n_fail++; $display("FAIL ovf_read[%0d]: got %h want %h", i, d, mq[0]); end
      void'(mq.pop_front());
    end
    n_tests++; if (bus.fifo_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain: got %b/%b want 0/1", bus.fifo_valid, overflow); end
  endtask

  task automatic test_timeout();
    int e0;
    logic [7:0] d;
    do_reset();
    e0 = err_cycles;
    send_bits(mk(8'h55, 0), 5);
    repeat (TMO + 50) @(negedge clk);
    send_frame(8'h32, 0);
    n_tests++; if (err_cycles !== e0) begin n_fail++; $display("FAIL timeout_err: got %0d pulses want 0", err_cycles - e0); end
    n_tests++; if (bus.fifo_valid !== 1'b1 || bus.fifo_data !== 8'h32) begin n_fail++; $display("FAIL timeout_data: got %b/%h want 1/32", bus.fifo_valid, bus.fifo_data); end
    pop_byte(d);
    n_tests++; if (bus.fifo_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_single: got %b want 0", bus.fifo_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] codes [5];
    logic [10:0] bits;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    foreach (codes[i]) send_frame(codes[i], 0);
    n_tests++; if (press_cnt !== 8'd5 || key_down !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got %0d/%b want 5/1", press_cnt, key_down); end
    bits = mk(8'h1C, 0);
    send_bits(bits, 6);
    @(negedge clk); rst = 1'b1; #1;
    n_tests++; if ({bus.fifo_valid, overflow, frame_err, key_down, cur_code, press_cnt} !== 20'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", {bus.fifo_valid, overflow, frame_err, key_down, cur_code, press_cnt}); end
    model_reset();
    repeat (2) @(negedge clk); rst = 1'b0;
    bits = bits >> 6;
    send_bits(bits, 5);
    repeat (TMO + 50) @(negedge clk);
    send_frame(8'h1C, 0);
    n_tests++; if (press_cnt !== 8'd1 || cur_code !== 8'h1C) begin n_fail++; $display("FAIL mid_after: got %0d/%h want 1/1c", press_cnt, cur_code); end
  endtask

  task automatic test_random();
    logic [7:0] pool [4];
    logic [7:0] b, d;
    int kind, e0, r;
    pool = '{8'h1C, 8'h32, 8'h23, 8'h2B};
    do_reset();
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) b = 8'hE0;
      else if (r <= 2) b = 8'hF0;
      else if (r <= 8) b = pool[$urandom_range(0, 3)];
      else b = 8'($urandom_range(0, 255));
      kind = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      e0 = err_cycles;
      send_frame(b, kind);
      n_tests++; if (err_cycles - e0 !== ((kind != 0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd_err[%0d]: got %0d want %0d", it, err_cycles - e0, (kind != 0) ? 1 : 0); end
      n_tests++; if (cur_code !== m_cur || key_down !== m_down || press_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_tracker[%0d]: got %h/%b/%0d want %h/%b/%0d", it, cur_code, key_down, press_cnt, m_cur, m_down, m_cnt); end
      n_tests++; if (overflow !== m_ovf || bus.fifo_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_fifo_flags[%0d]: got %b/%b want %b/%b", it, overflow, bus.fifo_valid, m_ovf, mq.size() != 0); end
      if (mq.size() != 0 && $urandom_range(0, 1) == 1) begin
        pop_byte(d);
        n_tests++; if (d !== mq[0]) begin n_fail++; $display("FAIL rnd_pop[%0d]: got %h want %h", it, d, mq[0]); end
        void'(mq.pop_front());
      end
    end
  endtask

  initial begin
    bus.fifo_rd = 1'b0;
    model_reset();
    test_reset();
    test_single_make();
    test_typematic_release();
    test_bad_frames();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
